// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: sole regfile write-port driver merging pipeline writebacks with FIFO-buffered multdiv results.
// Define REGFILE_BYPASS_EN to forward pending values instead of flagging hazards.
module regfile_wb_arbiter #(
    parameter int DEPTH = 4,
    parameter int RW    = 5,
    parameter int DW    = 32
) (
    input  logic                         clock,
    input  logic                         ctrl_reset_n,
    input  logic                         wb_valid,
    input  logic [RW-1:0]                wb_reg,
    input  logic [DW-1:0]                wb_data,
    input  logic                         md_valid,
    output logic                         md_ready,
    input  logic [RW-1:0]                md_reg,
    input  logic [DW-1:0]                md_data,
    output logic                         ctrl_writeEn,
    output logic [RW-1:0]                ctrl_writeReg,
    output logic [DW-1:0]                data_writeReg,
    input  logic [RW-1:0]                ctrl_readRegA,
    input  logic [RW-1:0]                ctrl_readRegB,
    output logic                         hazard_A,
    output logic                         hazard_B,
    output logic                         fwd_valid_A,
    output logic                         fwd_valid_B,
    output logic [DW-1:0]                fwd_data_A,
    output logic [DW-1:0]                fwd_data_B,
    output logic [$clog2(DEPTH+1)-1:0]   pending_cnt
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] kill_q, kill_d;
    logic [RW-1:0]    ent_reg_q [DEPTH];
    logic [DW-1:0]    ent_data_q [DEPTH];
    logic             we_q, we_d;
    logic [RW-1:0]    wreg_q, wreg_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic             wb_sel, md_live, pop, direct, push;
    logic [DW:0]      look_a, look_b;

    assign md_ready      = count_q < CW'(DEPTH);
    assign pending_cnt   = count_q;
    assign ctrl_writeEn  = we_q;
    assign ctrl_writeReg = wreg_q;
    assign data_writeReg = wdata_q;

    always_comb begin
        wb_sel  = wb_valid && wb_reg != '0;
        md_live = md_valid && md_ready && md_reg != '0;
        pop     = !wb_sel && count_q != '0;
        direct  = !wb_sel && count_q == '0 && md_live;
        // A same-cycle md to the register wb is writing is already stale.
        push    = md_live && !direct && !(wb_sel && md_reg == wb_reg);
        we_d    = wb_sel || (pop && !kill_q[head_q]) || direct;
        wreg_d  = wb_sel ? wb_reg : pop ? ent_reg_q[head_q] : md_reg;
        wdata_d = wb_sel ? wb_data : pop ? ent_data_q[head_q] : md_data;
        head_d  = pop ? head_q + PW'(1) : head_q;
        tail_d  = push ? tail_q + PW'(1) : tail_q;
        count_d = count_q + CW'(push) - CW'(pop);
        kill_d  = kill_q;
        for (int k = 0; k < DEPTH; k++)
            if (wb_sel && ent_reg_q[k] == wb_reg) kill_d[k] = 1'b1;
        if (push) kill_d[tail_q] = 1'b0;
    end

    // Walk oldest to newest so the youngest unkilled FIFO match wins over the output stage.
    function automatic logic [DW:0] lookup(input logic [RW-1:0] r);
        logic [DW:0]   res;
        logic [PW-1:0] idx;
        res = (we_q && wreg_q == r) ? {1'b1, wdata_q} : '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PW'(k);
            if (CW'(k) < count_q && !kill_q[idx] && ent_reg_q[idx] == r) res = {1'b1, ent_data_q[idx]};
        end
        return (r == '0) ? '0 : res;
    endfunction

    always_comb begin
        look_a = lookup(ctrl_readRegA);
        look_b = lookup(ctrl_readRegB);
    end

`ifdef REGFILE_BYPASS_EN
    assign hazard_A    = 1'b0;
    assign hazard_B    = 1'b0;
    assign fwd_valid_A = look_a[DW];
    assign fwd_valid_B = look_b[DW];
    assign fwd_data_A  = look_a[DW-1:0];
    assign fwd_data_B  = look_b[DW-1:0];
`else
    assign hazard_A    = look_a[DW];
    assign hazard_B    = look_b[DW];
    assign fwd_valid_A = 1'b0;
    assign fwd_valid_B = 1'b0;
    assign fwd_data_A  = '0;
    assign fwd_data_B  = '0;
`endif

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            kill_q  <= '0;
            we_q    <= 1'b0;
            wreg_q  <= '0;
            wdata_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            kill_q  <= kill_d;
            we_q    <= we_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            ent_reg_q[tail_q]  <= md_reg;
            ent_data_q[tail_q] <= md_data;
        end
    end
endmodule
